// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared FSM encodings and default constants for PWM capture and generation
package pwm_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MEAS  = 2'd1,
      ST_STALE = 2'd2
   } pwm_state_e;

   localparam int PWM_CNT_W_DEF    = 17;
   localparam int PWM_TIMEOUT_DEF  = 32000;
   localparam int PWM_FILT_LEN_DEF = 4;

endpackage

// File: rtl/pwm_capture_sync_filter.sv
// rtl/pwm_capture_sync_filter.sv - 2-flop synchronizer with optional glitch filter (PWM_CAPTURE_GLITCH_FILTER_EN)
module sync_filter
   import pwm_capture_pkg::*;
#(
   parameter int FILT_LEN = PWM_FILT_LEN_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam bit FILT_ON = 1'b1;
`else
   localparam bit FILT_ON = 1'b0;
`endif

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   // Synchronizer next-state: plain shift of the asynchronous input.
   always_comb begin
      s1_d = din;
      s2_d = s1_q;
   end

   // Two-flop synchronizer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   generate
      if (FILT_ON && (FILT_LEN > 0)) begin : g_filt
         localparam int FW = $clog2(FILT_LEN + 1);
         localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
         localparam logic [FW-1:0] FILT_ONE  = FW'(1);

         logic [FW-1:0] cnt_q, cnt_d;
         logic          lvl_q, lvl_d;

         // Count consecutive cycles the synchronized input disagrees with the
         // filtered level; adopt the new value once it has held FILT_LEN cycles.
         always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (s2_q != lvl_q) begin
               if (cnt_q == FILT_LAST) begin
                  lvl_d = s2_q;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + FILT_ONE;
               end
            end
         end

         // Filter state register.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q <= '0;
               lvl_q <= 1'b0;
            end else begin
               cnt_q <= cnt_d;
               lvl_q <= lvl_d;
            end
         end

         assign dout = lvl_q;
      end else begin : g_bypass
         assign dout = s2_q;
      end
   endgenerate

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture with stale detection; glitch filter via PWM_CAPTURE_GLITCH_FILTER_EN
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CNT_W    = PWM_CNT_W_DEF,
   parameter int TIMEOUT  = PWM_TIMEOUT_DEF,
   parameter int FILT_LEN = PWM_FILT_LEN_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             stale,
   output logic             level
);

   // The timeout counter is kept separate from period_cnt so the stale
   // timeout still works when TIMEOUT exceeds the saturating counter range.
   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   pwm_state_e       state_q, state_d;
   logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
   logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_time_q, high_time_d;
   logic             valid_q, valid_d;
   logic             stale_q, stale_d;
   logic             level_prev_q, level_prev_d;
   logic             rise;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? CNT_MAX : v + CNT_ONE;
   endfunction

   sync_filter #(
      .FILT_LEN (FILT_LEN)
   ) u_sync_filter (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (pwm_in),
      .dout  (level)
   );

   assign rise = level & ~level_prev_q;

   // Next-state, counter and output logic. The rise cycle itself is high, so
   // high_cnt restarts at 1 while period_cnt restarts at 0 and is loaded +1.
   always_comb begin
      state_d      = state_q;
      period_cnt_d = period_cnt_q;
      high_cnt_d   = high_cnt_q;
      to_cnt_d     = to_cnt_q;
      period_d     = period_q;
      high_time_d  = high_time_q;
      valid_d      = 1'b0;
      stale_d      = stale_q;
      level_prev_d = level;

      if (!enable) begin
         state_d      = ST_IDLE;
         period_cnt_d = '0;
         high_cnt_d   = '0;
         to_cnt_d     = '0;
         period_d     = '0;
         high_time_d  = '0;
         stale_d      = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               period_cnt_d = '0;
               high_cnt_d   = '0;
               to_cnt_d     = '0;
               if (rise) begin
                  state_d    = ST_MEAS;
                  high_cnt_d = CNT_ONE;
               end
            end
            ST_MEAS: begin
               if (rise) begin
                  period_d     = sat_inc(period_cnt_q);
                  high_time_d  = high_cnt_q;
                  valid_d      = 1'b1;
                  stale_d      = 1'b0;
                  period_cnt_d = '0;
                  high_cnt_d   = CNT_ONE;
                  to_cnt_d     = '0;
               end else if (to_cnt_q == TO_LAST) begin
                  state_d      = ST_STALE;
                  stale_d      = 1'b1;
                  period_d     = '0;
                  high_time_d  = '0;
                  period_cnt_d = '0;
                  high_cnt_d   = '0;
                  to_cnt_d     = '0;
               end else begin
                  period_cnt_d = sat_inc(period_cnt_q);
                  to_cnt_d     = to_cnt_q + TO_ONE;
                  if (level) begin
                     high_cnt_d = sat_inc(high_cnt_q);
                  end
               end
            end
            ST_STALE: begin
               if (rise) begin
                  state_d      = ST_MEAS;
                  period_cnt_d = '0;
                  high_cnt_d   = CNT_ONE;
                  to_cnt_d     = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         period_cnt_q <= '0;
         high_cnt_q   <= '0;
         to_cnt_q     <= '0;
         period_q     <= '0;
         high_time_q  <= '0;
         valid_q      <= 1'b0;
         stale_q      <= 1'b0;
         level_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_cnt_q <= period_cnt_d;
         high_cnt_q   <= high_cnt_d;
         to_cnt_q     <= to_cnt_d;
         period_q     <= period_d;
         high_time_q  <= high_time_d;
         valid_q      <= valid_d;
         stale_q      <= stale_d;
         level_prev_q <= level_prev_d;
      end
   end

   assign period    = period_q;
   assign high_time = high_time_q;
   assign valid     = valid_q;
   assign stale     = stale_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

   localparam int CNT_W    = 8;
   localparam int TIMEOUT  = 300;
   localparam int FILT_LEN = 4;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int LAT = 3 + FILT_LEN;
`else
   localparam int LAT = 3;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enable;
   logic             pwm_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             valid;
   logic             stale;
   logic             level;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int vper_q[$];
   int vhigh_q[$];
   int vcyc_q[$];
   int rise_cyc = 0;
   int stale_cyc = -1;
   logic stale_prev = 1'b0;
   int r2;
   int lv;

   pwm_capture #(
      .CNT_W    (CNT_W),
      .TIMEOUT  (TIMEOUT),
      .FILT_LEN (FILT_LEN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .pwm_in    (pwm_in),
      .period    (period),
      .high_time (high_time),
      .valid     (valid),
      .stale     (stale),
      .level     (level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         vper_q.push_back(int'(period));
         vhigh_q.push_back(int'(high_time));
         vcyc_q.push_back(cyc);
      end
      if (stale === 1'b1 && stale_prev !== 1'b1) stale_cyc = cyc;
      stale_prev = stale;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input int n);
      if (v && !pwm_in) rise_cyc = cyc;
      pwm_in = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      vper_q.delete();
      vhigh_q.delete();
      vcyc_q.delete();
   endtask

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_period", period, 0);
      check("rst_high", high_time, 0);
      check("rst_valid", valid, 0);
      check("rst_stale", stale, 0);
      check("rst_level", level, 0);

      rst_n  = 1'b1;
      enable = 1'b1;
      drive(0, 10);

      // five periods of 160/40
      r2 = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 40);
         if (i == 1) r2 = rise_cyc;
         if (i == 2) check("level_high", level, 1);
         drive(0, 120);
      end
      check("meas_count", vper_q.size(), 4);
      for (int k = 0; k < vper_q.size(); k++) begin
         check("meas_period", vper_q[k], 160);
         check("meas_high", vhigh_q[k], 40);
      end
      check("meas_latency", vcyc_q[0] - r2, LAT);
      check("meas_stale", stale, 0);
      lv = vcyc_q[vcyc_q.size() - 1];

      // input held low -> stale
      drive(0, 400);
      check("stale_set", stale, 1);
      check("stale_period", period, 0);
      check("stale_high", high_time, 0);
      check("stale_novalid", vper_q.size(), 4);
      check("stale_timing", stale_cyc - lv, TIMEOUT);

      // recovery from stale
      clear_q();
      drive(1, 40);
      drive(0, 120);
      check("recov_first_novalid", vper_q.size(), 0);
      check("recov_still_stale", stale, 1);
      drive(1, 40);
      drive(0, 120);
      check("recov_count", vper_q.size(), 1);
      check("recov_period", period, 160);
      check("recov_stale_clr", stale, 0);

      // 2-cycle glitch in low phase
      drive(1, 40);
      clear_q();
      drive(0, 58);
      drive(1, 2);
      drive(0, 60);
      drive(1, 40);
      drive(0, 120);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      check("glitch_count", vper_q.size(), 1);
      check("glitch_period", vper_q[0], 160);
      check("glitch_high", vhigh_q[0], 40);
`else
      check("glitch_count", vper_q.size(), 2);
      check("glitch_period0", vper_q[0], 98);
      check("glitch_high0", vhigh_q[0], 40);
      check("glitch_period1", vper_q[1], 62);
      check("glitch_high1", vhigh_q[1], 2);
`endif

      // asynchronous reset mid-period
      drive(1, 40);
      drive(0, 50);
      check("prerst_period", period, 160);
      rst_n = 1'b0;
      #2;
      check("arst_period", period, 0);
      check("arst_high", high_time, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_q();
      drive(0, 70);
      drive(1, 40);
      drive(0, 120);
      check("rst_first_novalid", vper_q.size(), 0);
      drive(1, 40);
      drive(0, 120);
      check("rst_second_count", vper_q.size(), 1);
      check("rst_second_period", period, 160);
      check("rst_second_high", high_time, 40);

      // enable dropped for one cycle
      drive(1, 40);
      drive(0, 30);
      check("preen_period", period, 160);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("en_period", period, 0);
      check("en_high", high_time, 0);
      check("en_stale", stale, 0);
      check("en_valid", valid, 0);
      enable = 1'b1;
      clear_q();
      drive(0, 90);
      drive(1, 40);
      drive(0, 120);
      check("en_first_novalid", vper_q.size(), 0);
      drive(1, 40);
      drive(0, 120);
      check("en_second_count", vper_q.size(), 1);
      check("en_second_period", period, 160);

      // edge exactly at timeout: edge wins, period saturates
      drive(1, 100);
      clear_q();
      drive(0, 200);
      drive(1, 40);
      drive(0, 10);
      check("edge_to_count", vper_q.size(), 1);
      check("edge_to_period", period, 255);
      check("edge_to_high", high_time, 100);
      check("edge_to_stale", stale, 0);

      // both counters saturate
      drive(0, 110);
      drive(1, 270);
      clear_q();
      drive(0, 20);
      drive(1, 10);
      check("sat_count", vper_q.size(), 1);
      check("sat_period", period, 255);
      check("sat_high", high_time, 255);

      // 100% duty after a 1-cycle low
      drive(0, 1);
      drive(1, 400);
      check("full_stale", stale, 1);
      check("full_level", level, 1);
      check("full_high", high_time, 0);
      check("full_period", period, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 17: width of the period and high-time counters and outputs.
REQ-002 SHALL have parameter TIMEOUT, default 32000: number of cycles without a rising edge before the input is declared stale.
REQ-003 SHALL have parameter FILT_LEN, default 4: number of stable cycles the glitch filter requires (used only with the filter macro).
REQ-004 SHALL have port clk  input  1: 16 MHz system clock; all state is clocked on the rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port enable  input  1: synchronous clear when low; measurement runs when high.
REQ-007 SHALL have port pwm_in  input  1: asynchronous PWM signal under measurement.
REQ-008 SHALL have port period  output  CNT_W: last measured period in clk cycles.
REQ-009 SHALL have port high_time  output  CNT_W: last measured high time in clk cycles.
REQ-010 SHALL have port valid  output  1: one-cycle pulse on each period/high_time update.
REQ-011 SHALL have port stale  output  1: high when no rising edge has occurred for TIMEOUT cycles.
REQ-012 SHALL have port level  output  1: filtered, synchronized pwm_in.

Function
REQ-013 SHALL pass pwm_in through a 2-flop synchronizer, then edge-detect the synchronized signal (the filtered signal when the filter is compiled in).
REQ-014 SHALL implement an FSM with states IDLE, MEAS and STALE.
REQ-015 IDLE: counters held at 0; on the first detected rising edge go to MEAS without asserting valid.
REQ-016 MEAS: period_cnt increments every cycle; high_cnt increments every cycle in which level=1.
REQ-017 MEAS, on a rising edge: load period<=period_cnt+1 and high_time<=high_cnt; pulse valid for 1 cycle; restart both counters; clear stale.
REQ-018 The measurement SHALL be exact: a 16000-cycle period with a 4000-cycle high phase yields period=16000 and high_time=4000.
REQ-019 Latency from a pwm_in rising edge to valid SHALL be 3 clk cycles, plus FILT_LEN when the filter is compiled in.
REQ-020 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 MEAS, when period_cnt reaches TIMEOUT-1 with no edge: go to STALE; set stale=1, period=0, high_time=0; do not pulse valid.
REQ-022 STALE: on a rising edge, go to MEAS with counters restarted; the first full period after the edge produces valid.
REQ-023 A rising edge and a timeout in the same cycle SHALL be resolved in favour of the edge.
REQ-024 enable=0 SHALL force IDLE, zero all counters and outputs except level, and take effect on the next clk edge.

Reset
REQ-025 While rst_n=0: state=IDLE; period, high_time, valid, stale and level=0; synchronizer and filter flops=0.
REQ-026 Reset asserted mid-measurement SHALL discard the partial count; after release, the first valid requires two rising edges.

Configuration
REQ-027 With macro PWM_CAPTURE_GLITCH_FILTER_EN defined, level SHALL change only after the synchronized input has held its new value for FILT_LEN consecutive cycles.
REQ-028 With the macro undefined, level SHALL equal the synchronizer output directly, and FILT_LEN SHALL be unused.

Structure
REQ-029 The FSM state encodings and the default CNT_W/TIMEOUT/FILT_LEN constants SHALL live in a shared package include also used by the pwm generator.
REQ-030 The synchronizer and optional filter SHALL be one sub-module, sync_filter, reusable for the encoder and IR inputs.

Verification
REQ-031 16000-cycle period, 4000 high, 5 periods -> 4 valid pulses, each with period=16000, high_time=4000, stale=0.
REQ-032 pwm_in held low 40000 cycles after 2 periods -> stale=1 and period=0 exactly 32000 cycles after the last rising edge; no valid.
REQ-033 2-cycle high glitch inside a low phase, FILT_LEN=4 -> with the macro, ignored (high_time unchanged); without the macro, counted and an extra valid is produced.
REQ-034 rst_n pulled low for 3 cycles mid-period -> outputs 0 immediately (asynchronous); next valid only after the second post-reset rising edge.
REQ-035 enable dropped for 1 cycle during MEAS -> outputs cleared next cycle; behaviour is then identical to IDLE restart.
REQ-036 100% duty (pwm_in held high) after a 1-cycle low -> stale=1 after TIMEOUT, level=1, high_time=0.
